// File: rtl/instr_sequencer.sv
// instr_sequencer: steps through a fixed 8-entry instruction ROM. Each
// instruction is presented for HOLD_CYCLES cycles. Branches are taken from the
// datapath br flag, and the program finishes on the entry flagged "last".
// All outputs are registered.
// Optional feature macro: SINGLE_STEP_EN adds a step input and a WAIT_STEP state
// that pauses between instruction windows.
module instr_sequencer #(
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       halt,
  input  logic       br,
`ifdef SINGLE_STEP_EN
  input  logic       step,
`endif
  output logic [2:0] instruction_A,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] beq_sw,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_HOLD      = 3'd2;
  localparam logic [2:0] ST_DONE      = 3'd3;
  localparam logic [2:0] ST_WAIT_STEP = 3'd4;

  localparam logic [3:0] HOLD_RELOAD = 4'(HOLD_CYCLES - 32'd1);

  // ROM word layout: {last, target[2:0], beq_sw[3:0], MemWrite, RegWrite}
  function automatic logic [9:0] rom_word(input logic [2:0] addr);
    logic [9:0] w;
    case (addr)
      3'd0:    w = 10'b0_000_0000_0_0;
      3'd1:    w = 10'b0_000_0000_0_1;
      3'd2:    w = 10'b0_000_0000_1_0;
      3'd3:    w = 10'b0_000_0000_0_1;
      3'd4:    w = 10'b0_000_0000_0_0;
      3'd5:    w = 10'b0_111_0001_0_0;
      3'd6:    w = 10'b0_000_0010_0_1;
      3'd7:    w = 10'b1_000_0000_0_0;
      default: w = 10'b0_000_0000_0_0;
    endcase
    return w;
  endfunction

  logic [2:0] state_r;
  logic [2:0] seq_pc_r;
  logic [3:0] hold_cnt_r;

  logic [2:0] state_next_s;
  logic [2:0] pc_next_s;
  logic [3:0] cnt_next_s;
  logic [9:0] rom_s;
  logic       window_end_s;
  logic [2:0] branch_pc_s;

  logic [2:0] a_next_s;
  logic       rw_next_s;
  logic       mw_next_s;
  logic [3:0] beq_next_s;
  logic       busy_next_s;
  logic       done_next_s;

  // Decode the current ROM entry and decide where the window goes next
  always_comb begin
    rom_s        = rom_word(seq_pc_r);
    window_end_s = ((state_r == ST_ISSUE) && (HOLD_RELOAD == 4'd0)) ||
                   ((state_r == ST_HOLD) && (hold_cnt_r <= 4'd1));
    if ((rom_s[5:2] != 4'd0) && br) begin
      branch_pc_s = rom_s[8:6];
    end else begin
      branch_pc_s = seq_pc_r + 3'd1;
    end
  end

  // Next-state, program counter and hold counter selection
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = seq_pc_r;
    cnt_next_s   = hold_cnt_r;
    if (halt) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_next_s = ST_ISSUE;
            pc_next_s    = 3'd0;
          end else begin
            state_next_s = state_r;
          end
        end
        ST_ISSUE, ST_HOLD: begin
          if (state_r == ST_ISSUE) begin
            cnt_next_s = HOLD_RELOAD;
          end else begin
            cnt_next_s = hold_cnt_r - 4'd1;
          end
          if (!window_end_s) begin
            state_next_s = ST_HOLD;
          end else if (rom_s[9]) begin
            state_next_s = ST_DONE;
          end else begin
            pc_next_s = branch_pc_s;
`ifdef SINGLE_STEP_EN
            state_next_s = ST_WAIT_STEP;
`else
            state_next_s = ST_ISSUE;
`endif
          end
        end
        ST_WAIT_STEP: begin
`ifdef SINGLE_STEP_EN
          if (step) begin
            state_next_s = ST_ISSUE;
          end else begin
            state_next_s = ST_WAIT_STEP;
          end
`else
          state_next_s = ST_IDLE;
`endif
        end
        default: state_next_s = ST_IDLE;
      endcase
    end
  end

  // Output values for the next cycle; a window's outputs are loaded in ISSUE
  always_comb begin
    a_next_s    = instruction_A;
    rw_next_s   = 1'b0;
    mw_next_s   = 1'b0;
    beq_next_s  = 4'd0;
    busy_next_s = 1'b0;
    done_next_s = 1'b0;
    if (halt) begin
      busy_next_s = 1'b0;
    end else begin
      case (state_r)
        ST_ISSUE: begin
          a_next_s    = seq_pc_r;
          rw_next_s   = rom_s[0];
          mw_next_s   = rom_s[1];
          beq_next_s  = rom_s[5:2];
          busy_next_s = 1'b1;
        end
        ST_HOLD: begin
          rw_next_s   = RegWrite;
          mw_next_s   = MemWrite;
          beq_next_s  = beq_sw;
          busy_next_s = 1'b1;
        end
        ST_WAIT_STEP: busy_next_s = 1'b1;
        ST_DONE:      done_next_s = !start;
        default:      busy_next_s = 1'b0;
      endcase
    end
  end

  // State, program counter, hold counter and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      seq_pc_r      <= 3'd0;
      hold_cnt_r    <= 4'd0;
      instruction_A <= 3'd0;
      RegWrite      <= 1'b0;
      MemWrite      <= 1'b0;
      beq_sw        <= 4'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      seq_pc_r      <= pc_next_s;
      hold_cnt_r    <= cnt_next_s;
      instruction_A <= a_next_s;
      RegWrite      <= rw_next_s;
      MemWrite      <= mw_next_s;
      beq_sw        <= beq_next_s;
      busy          <= busy_next_s;
      done          <= done_next_s;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed, table-driven bench for instr_sequencer. It uses dut (HOLD_CYCLES=2)
// for the program runs, and dut1 (HOLD_CYCLES=1) for the single-cycle windows.
module tb_instr_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, halt, br;
  logic       start1, halt1, br1;
  logic [2:0] a, a1;
  logic       rw, mw, busy, done, rw1, mw1, busy1, done1;
  logic [3:0] beq, beq1;
`ifdef SINGLE_STEP_EN
  logic       step, step1;
`endif

  instr_sequencer #(.HOLD_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .br(br),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .instruction_A(a), .RegWrite(rw), .MemWrite(mw), .beq_sw(beq),
    .busy(busy), .done(done));

  instr_sequencer #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .halt(halt1), .br(br1),
`ifdef SINGLE_STEP_EN
    .step(step1),
`endif
    .instruction_A(a1), .RegWrite(rw1), .MemWrite(mw1), .beq_sw(beq1),
    .busy(busy1), .done(done1));

  typedef struct {
    logic        start;
    logic        halt;
    logic        br;
    logic [10:0] exp;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   failures = 0;

  // Expected ROM fields, one bit per entry: RegWrite on 1,3,6 and MemWrite on 2
  logic [7:0] rw_tbl = 8'h4A;
  logic [7:0] mw_tbl = 8'h04;

  function automatic logic [3:0] beq_of(input int e);
    if (e == 5) return 4'd1;
    if (e == 6) return 4'd2;
    return 4'd0;
  endfunction

  function automatic logic [10:0] pk(input logic [2:0] ea, input logic erw, input logic emw,
                                     input logic [3:0] ebeq, input logic ebusy, input logic edone);
    return {ea, erw, emw, ebeq, ebusy, edone};
  endfunction

  function automatic void push(input logic s, input logic h, input logic b, input logic [10:0] e);
    vec_t v;
    v.start = s; v.halt = h; v.br = b; v.exp = e;
    vq.push_back(v);
  endfunction

  // Two-cycle window for entry e, with br driven during both cycles
  function automatic void push_window(input int e, input logic b);
    for (int i = 0; i < 2; i++)
      push(1'b0, 1'b0, b, pk(3'(e), rw_tbl[e], mw_tbl[e], beq_of(e), 1'b1, 1'b0));
  endfunction

  task automatic check(input string nm, input logic [10:0] got, input logic [10:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b required=%b ({a[2:0],rw,mw,beq[3:0],busy,done})", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; halt = 1'b0; br = 1'b0;
    start1 = 1'b0; halt1 = 1'b0; br1 = 1'b0;
`ifdef SINGLE_STEP_EN
    step = 1'b0; step1 = 1'b0;
`endif
    #12;
    check("reset_dut", {a, rw, mw, beq, busy, done}, 11'd0);
    check("reset_dut1", {a1, rw1, mw1, beq1, busy1, done1}, 11'd0);
    rst = 1'b1;

`ifdef SINGLE_STEP_EN
    start = 1'b1; tick(); start = 1'b0;
    check("ss_start", {a, rw, mw, beq, busy, done}, pk(3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    for (int i = 0; i < 2; i++) begin
      tick();
      check("ss_win0", {a, rw, mw, beq, busy, done}, pk(3'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0));
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ss_wait", {a, rw, mw, beq, busy, done}, pk(3'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0));
    end
    step = 1'b1; tick(); step = 1'b0;
    check("ss_step", {a, rw, mw, beq, busy, done}, pk(3'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0));
    for (int i = 0; i < 2; i++) begin
      tick();
      check("ss_win1", {a, rw, mw, beq, busy, done}, pk(3'd1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0));
    end
    tick();
    check("ss_wait1", {a, rw, mw, beq, busy, done}, pk(3'd1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0));
    halt = 1'b1; step = 1'b1; tick(); halt = 1'b0; step = 1'b0;
    check("ss_halt", {a, rw, mw, beq, busy, done}, pk(3'd1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    tick();
    check("ss_idle", {a, rw, mw, beq, busy, done}, pk(3'd1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
`else
    // idle, then halt wins over start
    push(1'b0, 1'b0, 1'b0, pk(3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    push(1'b1, 1'b1, 1'b0, pk(3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    push(1'b0, 1'b0, 1'b0, pk(3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    // straight run, br=0: 0,0,1,1,...,7,7 then done
    push(1'b1, 1'b0, 1'b0, pk(3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    for (int e = 0; e < 8; e++) push_window(e, 1'b0);
    push(1'b0, 1'b0, 1'b0, pk(3'd7, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1));
    push(1'b0, 1'b0, 1'b0, pk(3'd7, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1));
    // restart from DONE, branch at entry 5 straight to 7
    push(1'b1, 1'b0, 1'b0, pk(3'd7, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    for (int e = 0; e < 5; e++) push_window(e, 1'b0);
    push_window(5, 1'b1);
    push_window(7, 1'b0);
    push(1'b0, 1'b0, 1'b0, pk(3'd7, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1));
    // entry 6 branches back to 0, then halt in entry 1
    push(1'b1, 1'b0, 1'b0, pk(3'd7, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    for (int e = 0; e < 6; e++) push_window(e, 1'b0);
    push_window(6, 1'b1);
    push_window(0, 1'b1);
    push(1'b0, 1'b0, 1'b1, pk(3'd1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0));
    push(1'b0, 1'b1, 1'b1, pk(3'd1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    push(1'b0, 1'b0, 1'b0, pk(3'd1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));

    foreach (vq[i]) begin
      start = vq[i].start; halt = vq[i].halt; br = vq[i].br;
      tick();
      check($sformatf("vec%0d", i), {a, rw, mw, beq, busy, done}, vq[i].exp);
    end
    start = 1'b0; halt = 1'b0; br = 1'b0;

    // asynchronous reset during entry 2 drops MemWrite without a clock edge
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    tick();
    check("rst_pre_mw", {a, rw, mw, beq, busy, done}, pk(3'd2, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0));
    #2 rst = 1'b0;
    #1 check("rst_async", {a, rw, mw, beq, busy, done}, 11'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_idle", {a, rw, mw, beq, busy, done}, 11'd0);
    end
    start = 1'b1; tick(); start = 1'b0;
    tick();
    check("rst_restart", {a, rw, mw, beq, busy, done}, pk(3'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0));
    halt = 1'b1; tick(); halt = 1'b0;

    // HOLD_CYCLES=1: one cycle per entry
    start1 = 1'b1; tick(); start1 = 1'b0;
    check("h1_start", {a1, rw1, mw1, beq1, busy1, done1}, 11'd0);
    for (int e = 0; e < 8; e++) begin
      tick();
      check($sformatf("h1_e%0d", e), {a1, rw1, mw1, beq1, busy1, done1},
            pk(3'(e), rw_tbl[e], mw_tbl[e], beq_of(e), 1'b1, 1'b0));
    end
    tick();
    check("h1_done", {a1, rw1, mw1, beq1, busy1, done1}, pk(3'd7, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
